// File: rtl/traffic_phase_sequencer.sv
// N-direction green/yellow/all-red sequencer with emergency preemption.
// Optional pedestrian walk phase when PED_REQ_EN is defined.
module traffic_phase_sequencer #(
  parameter int NUM_DIR    = 3,
  parameter int GREEN_CYC  = 5000000,
  parameter int YELLOW_CYC = 2000000,
  parameter int ALLRED_CYC = 500000,
  parameter int PED_CYC    = 3000000,
  parameter int TW         = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 emergency,
  input  logic [1:0]           emg_dir,
`ifdef PED_REQ_EN
  input  logic                 ped_req,
  output logic                 ped_walk,
`endif
  output logic [3*NUM_DIR-1:0] lights,
  output logic [1:0]           phase,
  output logic                 emg_active
);

  typedef enum logic [2:0] {
    S_GREEN,
    S_YELLOW,
    S_ALLRED,
    S_EMG_HOLD,
    S_PED_WALK
  } state_t;

  localparam logic [TW-1:0] G_LAST = TW'(GREEN_CYC - 1);
  localparam logic [TW-1:0] Y_LAST = TW'(YELLOW_CYC - 1);
  localparam logic [TW-1:0] A_LAST = TW'(ALLRED_CYC - 1);
  localparam logic [TW-1:0] P_LAST = TW'(PED_CYC - 1);

  state_t        state, state_n;
  logic [1:0]    phase_n;
  logic [1:0]    nxt;
  logic [TW-1:0] timer;
  logic          emg_ok;
`ifdef PED_REQ_EN
  logic          pend, pend_n;
`endif

  assign emg_ok = emergency && ({1'b0, emg_dir} < 3'(NUM_DIR));
  assign nxt    = (phase == 2'(NUM_DIR - 1)) ? 2'd0 : phase + 2'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_GREEN;
      phase <= 2'd0;
      timer <= '0;
    end else begin
      state <= state_n;
      phase <= phase_n;
      timer <= (state_n != state) ? '0 : timer + TW'(1);
    end
  end

  always_comb begin
    state_n = state;
    phase_n = phase;
    case (state)
      S_GREEN: begin
        if (emg_ok)
          state_n = (phase == emg_dir) ? S_EMG_HOLD : S_YELLOW;
        else if (timer == G_LAST)
          state_n = S_YELLOW;
      end
      S_YELLOW: begin
        if (timer == Y_LAST)
          state_n = S_ALLRED;
      end
      S_ALLRED: begin
        if (timer == A_LAST) begin
          if (emg_ok) begin
            state_n = S_EMG_HOLD;
            phase_n = emg_dir;
          end
`ifdef PED_REQ_EN
          else if (pend)
            state_n = S_PED_WALK;
`endif
          else begin
            state_n = S_GREEN;
            phase_n = nxt;
          end
        end
      end
      S_EMG_HOLD: begin
        if (!emg_ok || emg_dir != phase)
          state_n = S_YELLOW;
      end
`ifdef PED_REQ_EN
      S_PED_WALK: begin
        if (emg_ok)
          state_n = S_ALLRED;
        else if (timer == P_LAST) begin
          state_n = S_GREEN;
          phase_n = nxt;
        end
      end
`endif
      default: state_n = S_GREEN;
    endcase
  end

  always_comb begin
    lights = '0;
    for (int d = 0; d < NUM_DIR; d++) begin
      if (2'(d) == phase &&
          (state == S_GREEN || state == S_EMG_HOLD))
        lights[3*d +: 3] = 3'b001;
      else if (2'(d) == phase && state == S_YELLOW)
        lights[3*d +: 3] = 3'b010;
      else
        lights[3*d +: 3] = 3'b100;
    end
  end

  assign emg_active = (state == S_EMG_HOLD);

`ifdef PED_REQ_EN
  // An aborted walk re-arms the request so it is served after the emergency.
  always_comb begin
    pend_n = pend;
    if (state != S_PED_WALK && state_n == S_PED_WALK)
      pend_n = 1'b0;
    if (state == S_PED_WALK && state_n == S_ALLRED)
      pend_n = 1'b1;
    if (ped_req)
      pend_n = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      pend <= 1'b0;
    else
      pend <= pend_n;
  end

  assign ped_walk = (state == S_PED_WALK);
`else
  logic unused_ped;
  assign unused_ped = ^P_LAST;
`endif

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Directed bench for traffic_phase_sequencer (NUM_DIR=3, G=5, Y=2, R=1, PED=3).
// Observations are taken on the falling edge; inputs change there too.
module tb_traffic_phase_sequencer;

  localparam logic [8:0] G0 = 9'b100_100_001;
  localparam logic [8:0] Y0 = 9'b100_100_010;
  localparam logic [8:0] G1 = 9'b100_001_100;
  localparam logic [8:0] Y1 = 9'b100_010_100;
  localparam logic [8:0] G2 = 9'b001_100_100;
  localparam logic [8:0] Y2 = 9'b010_100_100;
  localparam logic [8:0] RR = 9'b100_100_100;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       emergency = 1'b0;
  logic [1:0] emg_dir = 2'd0;
  logic [8:0] lights;
  logic [1:0] phase;
  logic       emg_active;
`ifdef PED_REQ_EN
  logic       ped_req = 1'b0;
  logic       ped_walk;
`endif

  int errors = 0;
  int checks = 0;

  traffic_phase_sequencer #(
    .NUM_DIR(3), .GREEN_CYC(5), .YELLOW_CYC(2),
    .ALLRED_CYC(1), .PED_CYC(3), .TW(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .emergency(emergency),
    .emg_dir(emg_dir),
`ifdef PED_REQ_EN
    .ped_req(ped_req),
    .ped_walk(ped_walk),
`endif
    .lights(lights),
    .phase(phase),
    .emg_active(emg_active)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached errors=%0d checks=%0d",
             errors, checks);
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    emergency = 1'b0;
    emg_dir = 2'd0;
`ifdef PED_REQ_EN
    ped_req = 1'b0;
`endif
    repeat (2) tick();
    reset = 1'b0;
  endtask

  // Free-run reference: 8-cycle slot per direction (G5, Y2, R1).
  function automatic logic [11:0] free_exp(int k);
    int m, p, r;
    logic [8:0] l;
    m = k % 24;
    p = m / 8;
    r = m % 8;
    if (r < 5)
      l = (p == 0) ? G0 : (p == 1) ? G1 : G2;
    else if (r < 7)
      l = (p == 0) ? Y0 : (p == 1) ? Y1 : Y2;
    else
      l = RR;
    return {l, 2'(p), 1'b0};
  endfunction

  task automatic test_reset();
    logic [11:0] exp;
    reset = 1'b1;
    repeat (2) tick();
    exp = {G0, 2'd0, 1'b0};
    checks++;
    if ({lights, phase, emg_active} !== exp) begin
      errors++;
      $display("FAIL reset got=%b want=%b",
               {lights, phase, emg_active}, exp);
    end
`ifdef PED_REQ_EN
    checks++;
    if (ped_walk !== 1'b0) begin
      errors++;
      $display("FAIL reset_walk got=%b want=0", ped_walk);
    end
`endif
    reset = 1'b0;
  endtask

  task automatic test_free_run();
    logic [11:0] exp;
    do_reset();
    for (int k = 0; k <= 24; k++) begin
      exp = free_exp(k);
      checks++;
      if ({lights, phase, emg_active} !== exp) begin
        errors++;
        $display("FAIL free_run k=%0d got=%b want=%b",
                 k, {lights, phase, emg_active}, exp);
      end
      tick();
    end
  endtask

  task automatic test_emg_preempt();
    logic [11:0] exp;
    do_reset();
    repeat (2) tick();
    emergency = 1'b1;
    emg_dir = 2'd2;
    tick();
    for (int k = 3; k <= 19; k++) begin
      if (k < 5)       exp = {Y0, 2'd0, 1'b0};
      else if (k == 5) exp = {RR, 2'd0, 1'b0};
      else if (k < 16) exp = {G2, 2'd2, 1'b1};
      else if (k < 18) exp = {Y2, 2'd2, 1'b0};
      else if (k == 18) exp = {RR, 2'd2, 1'b0};
      else             exp = {G0, 2'd0, 1'b0};
      checks++;
      if ({lights, phase, emg_active} !== exp) begin
        errors++;
        $display("FAIL emg_preempt k=%0d got=%b want=%b",
                 k, {lights, phase, emg_active}, exp);
      end
      if (k == 15) emergency = 1'b0;
      tick();
    end
  endtask

  task automatic test_emg_same_dir();
    logic [11:0] exp;
    do_reset();
    repeat (9) tick();
    for (int k = 9; k <= 28; k++) begin
      if (k == 9)       exp = {G1, 2'd1, 1'b0};
      else if (k <= 20) exp = {G1, 2'd1, 1'b1};
      else if (k <= 22) exp = {Y1, 2'd1, 1'b0};
      else if (k == 23) exp = {RR, 2'd1, 1'b0};
      else if (k == 24) exp = {G0, 2'd0, 1'b1};
      else if (k <= 26) exp = {Y0, 2'd0, 1'b0};
      else if (k == 27) exp = {RR, 2'd0, 1'b0};
      else              exp = {G1, 2'd1, 1'b0};
      checks++;
      if ({lights, phase, emg_active} !== exp) begin
        errors++;
        $display("FAIL emg_same_dir k=%0d got=%b want=%b",
                 k, {lights, phase, emg_active}, exp);
      end
      if (k == 9) begin
        emergency = 1'b1;
        emg_dir = 2'd1;
      end
      if (k == 20) emg_dir = 2'd0;
      if (k == 24) emergency = 1'b0;
      tick();
    end
  endtask

  task automatic test_invalid_dir();
    logic [11:0] exp;
    do_reset();
    emergency = 1'b1;
    emg_dir = 2'd3;
    for (int k = 0; k <= 29; k++) begin
      exp = free_exp(k);
      checks++;
      if ({lights, phase, emg_active} !== exp) begin
        errors++;
        $display("FAIL invalid_dir k=%0d got=%b want=%b",
                 k, {lights, phase, emg_active}, exp);
      end
      if (k < 29) tick();
    end
    emergency = 1'b0;
    reset = 1'b1;
    tick();
    exp = {G0, 2'd0, 1'b0};
    checks++;
    if ({lights, phase, emg_active} !== exp) begin
      errors++;
      $display("FAIL reset_in_yellow got=%b want=%b",
               {lights, phase, emg_active}, exp);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [11:0] exp;
    do_reset();
    repeat (5) tick();
    emergency = 1'b1;
    emg_dir = 2'd2;
    for (int k = 5; k <= 12; k++) begin
      if (k <= 6)       exp = {Y0, 2'd0, 1'b0};
      else if (k == 7)  exp = {RR, 2'd0, 1'b0};
      else if (k == 8)  exp = {G2, 2'd2, 1'b1};
      else if (k <= 10) exp = {Y2, 2'd2, 1'b0};
      else if (k == 11) exp = {RR, 2'd2, 1'b0};
      else              exp = {G0, 2'd0, 1'b0};
      checks++;
      if ({lights, phase, emg_active} !== exp) begin
        errors++;
        $display("FAIL emg_in_yellow k=%0d got=%b want=%b",
                 k, {lights, phase, emg_active}, exp);
      end
      if (k == 8) emergency = 1'b0;
      tick();
    end
    do_reset();
    repeat (2) tick();
    emergency = 1'b1;
    emg_dir = 2'd2;
    tick();
    emergency = 1'b0;
    for (int k = 3; k <= 6; k++) begin
      if (k <= 4)      exp = {Y0, 2'd0, 1'b0};
      else if (k == 5) exp = {RR, 2'd0, 1'b0};
      else             exp = {G1, 2'd1, 1'b0};
      checks++;
      if ({lights, phase, emg_active} !== exp) begin
        errors++;
        $display("FAIL emg_drop_clear k=%0d got=%b want=%b",
                 k, {lights, phase, emg_active}, exp);
      end
      tick();
    end
  endtask

`ifdef PED_REQ_EN
  task automatic test_ped();
    logic [12:0] exp;
    do_reset();
    for (int k = 0; k <= 28; k++) begin
      if (k <= 4)       exp = {G0, 2'd0, 1'b0, 1'b0};
      else if (k <= 6)  exp = {Y0, 2'd0, 1'b0, 1'b0};
      else if (k == 7)  exp = {RR, 2'd0, 1'b0, 1'b0};
      else if (k <= 10) exp = {RR, 2'd0, 1'b0, 1'b1};
      else if (k <= 15) exp = {G1, 2'd1, 1'b0, 1'b0};
      else if (k <= 17) exp = {Y1, 2'd1, 1'b0, 1'b0};
      else if (k == 18) exp = {RR, 2'd1, 1'b0, 1'b0};
      else if (k == 19) exp = {RR, 2'd1, 1'b0, 1'b1};
      else if (k == 20) exp = {RR, 2'd1, 1'b0, 1'b0};
      else if (k == 21) exp = {G0, 2'd0, 1'b1, 1'b0};
      else if (k <= 23) exp = {Y0, 2'd0, 1'b0, 1'b0};
      else if (k == 24) exp = {RR, 2'd0, 1'b0, 1'b0};
      else if (k <= 27) exp = {RR, 2'd0, 1'b0, 1'b1};
      else              exp = {G1, 2'd1, 1'b0, 1'b0};
      checks++;
      if ({lights, phase, emg_active, ped_walk} !== exp) begin
        errors++;
        $display("FAIL ped k=%0d got=%b want=%b",
                 k, {lights, phase, emg_active, ped_walk}, exp);
      end
      if (k == 1)  ped_req = 1'b1;
      if (k == 2)  ped_req = 1'b0;
      if (k == 12) ped_req = 1'b1;
      if (k == 13) ped_req = 1'b0;
      if (k == 19) begin
        emergency = 1'b1;
        emg_dir = 2'd0;
      end
      if (k == 21) emergency = 1'b0;
      tick();
    end
  endtask
`endif

  initial begin
    tick();
    test_reset();
    test_free_run();
    test_emg_preempt();
    test_emg_same_dir();
    test_invalid_dir();
    test_back_to_back();
`ifdef PED_REQ_EN
    test_ped();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
